gshare_predictor_v2: RTL and testbench
======================================

Name: gshare_predictor_v2

Overview:
Parametrised next-generation gshare conditional-branch direction predictor for the IF stage.
- PHT of saturating counters of configurable width and depth, with a selectable index hash (gshare XOR or bimodal).
- Speculative GHR with repair on mispredict: the GHR snapshot travels down the pipeline and is returned at resolve.
- Index is recomputed internally from the resolving PC and GHR.
- A reset-sweep FSM initialises the PHT after reset; the front end stalls on o_busy until the sweep finishes.

Parameters:
PC_WIDTH, 32, PC width
PHT_ENT_SEL, 10, PHT index bits; PHT holds 2^PHT_ENT_SEL entries
GHR_WIDTH, 10, global history length; must satisfy 2 <= GHR_WIDTH <= PHT_ENT_SEL
CTR_WIDTH, 2, counter width; must be >= 2
HASH_MODE, 0, 0 = gshare (PC XOR GHR), 1 = bimodal (PC only; GHR is still maintained)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_pc  in  PC_WIDTH  fetch PC to predict
i_pred_req  in  1  BTB hit on a conditional branch; consume prediction and shift GHR
o_pred_jmpcond  out  1  predicted taken (combinational)
o_pred_ghr  out  GHR_WIDTH  GHR value used for this lookup; carried with the branch
o_busy  out  1  PHT init sweep in progress
i_resolve_valid  in  1  conditional branch resolved; train PHT
i_resolve_pc  in  PC_WIDTH  PC of resolved branch
i_resolve_ghr  in  GHR_WIDTH  o_pred_ghr captured at prediction time
i_resolve_jmpcond  in  1  actual direction
i_resolve_mispred  in  1  direction mispredicted; qualified by i_resolve_valid

Behaviour:
- Index function: idx(pc,g) = pc[2 +: PHT_ENT_SEL] ^ {zero-extend g to PHT_ENT_SEL}.
  - HASH_MODE=1 drops the XOR term.
  - Prediction uses idx(i_pc, ghr); training uses idx(i_resolve_pc, i_resolve_ghr).
- Counter init value CINIT = 2^(CTR_WIDTH-1) - 1 (weakly not-taken); taken threshold is counter >= 2^(CTR_WIDTH-1).
- o_pred_jmpcond: combinational read of the PHT at the prediction index, zero-latency.
  - Forced 0 while o_busy=1.
- o_pred_ghr: equals the current GHR register; it is the pre-shift value.
- Init FSM, states INIT and RUN:
  - Async reset: state=INIT, sweep counter=0, ghr=0, o_busy=1.
  - INIT: each cycle PHT[counter] <= CINIT and the counter increments.
  - When counter == 2^PHT_ENT_SEL - 1, that entry is written and the FSM moves to RUN in the next cycle. INIT therefore lasts exactly 2^PHT_ENT_SEL cycles.
  - In INIT, i_pred_req and i_resolve_valid are ignored and ghr holds at 0.
  - RUN has no exit except reset. Reset asserted mid-operation re-enters INIT, clears ghr and re-sweeps the whole PHT.
- GHR update in RUN, with the priority below:
  1. i_resolve_valid & i_resolve_mispred: ghr <= {i_resolve_ghr[GHR_WIDTH-2:0], i_resolve_jmpcond}. A same-cycle i_pred_req is ignored for GHR purposes because the front end is being redirected.
  2. Otherwise, if i_pred_req: ghr <= {ghr[GHR_WIDTH-2:0], o_pred_jmpcond}.
  3. Otherwise ghr holds.
- PHT training in RUN on i_resolve_valid, single-cycle read-modify-write at the training index:
  - Taken: counter+1, saturating at 2^CTR_WIDTH-1.
  - Not-taken: counter-1, saturating at 0.
  - The training read uses a port independent of the prediction read.
  - Training happens whether or not the branch was mispredicted.
- Same-cycle prediction and training at the same index: the prediction returns the old counter (no write-to-read bypass). The updated value is visible from the next cycle.
- No other outputs are registered; the only state is the PHT, ghr, the FSM state and the sweep counter.

Test Plan:
- Reset, defaults: o_busy=1 for exactly 1024 cycles and o_pred_jmpcond=0 throughout. After that, o_busy=0, every index predicts 0 (counter=1) and o_pred_ghr=0.
- Training saturation: resolve pc=0x100, ghr=0 (idx 0x040), taken x3 -> counter 1->2->3->3. Prediction at pc=0x100, ghr=0 -> 1. Then not-taken x4 -> counter reaches 0 and stays there.
- GHR shift: train the three indices so the predictions are 1,0,1, then issue three i_pred_req -> ghr=0b101 and o_pred_ghr shows 0x000, 0x001, 0x002 at each request.
- Mispredict repair: i_resolve_mispred with i_resolve_ghr=0x3A5 and jmpcond=1, with i_pred_req high in the same cycle -> ghr=0x34B next cycle (the pred_req shift is discarded).
- Collision: predict and train the same index in one cycle (counter 1, taken) -> o_pred_jmpcond=0 that cycle and 1 the next cycle.
- Async reset mid-RUN with trained entries -> o_busy rises immediately and ghr=0. After the re-sweep, all entries predict 0.
- HASH_MODE=1 variant: the same pc gives the same prediction for ghr=0 and ghr=0x3FF.

Source files
------------

// File: rtl/gshare_predictor_v2.sv
// gshare direction predictor with speculative GHR, repair and PHT init sweep.
// Prediction reads the PHT combinationally; training is a 1-cycle RMW.
module gshare_predictor_v2 #(
  parameter int PC_WIDTH    = 32,
  parameter int PHT_ENT_SEL = 10,
  parameter int GHR_WIDTH   = 10,
  parameter int CTR_WIDTH   = 2,
  parameter int HASH_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PC_WIDTH-1:0]  i_pc,
  input  logic                 i_pred_req,
  output logic                 o_pred_jmpcond,
  output logic [GHR_WIDTH-1:0] o_pred_ghr,
  output logic                 o_busy,
  input  logic                 i_resolve_valid,
  input  logic [PC_WIDTH-1:0]  i_resolve_pc,
  input  logic [GHR_WIDTH-1:0] i_resolve_ghr,
  input  logic                 i_resolve_jmpcond,
  input  logic                 i_resolve_mispred
);

  localparam int unsigned N = 1 << PHT_ENT_SEL;

  typedef logic [PHT_ENT_SEL-1:0] idx_t;
  typedef logic [CTR_WIDTH-1:0]   ctr_t;
  typedef enum logic {INIT, RUN}  state_t;

  localparam ctr_t CMAX  = '1;
  localparam ctr_t CINIT =
    CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

  function automatic idx_t hash(
    input idx_t                 pcb,
    input logic [GHR_WIDTH-1:0] g
  );
    idx_t gh;
    gh = (HASH_MODE == 0) ? idx_t'(g) : '0;
    return pcb ^ gh;
  endfunction

  state_t               state_q, state_d;
  idx_t                 sweep_q;
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  ctr_t                 pht [N];

  idx_t pred_idx, trn_idx;
  ctr_t pred_ctr, trn_ctr, trn_new;
  logic run, repair, shift;

  // Bits outside the index field do not take part in the hash.
  logic unused_pc;
  assign unused_pc = ^{i_pc[1:0],
                       i_pc[PC_WIDTH-1:PHT_ENT_SEL+2],
                       i_resolve_pc[1:0],
                       i_resolve_pc[PC_WIDTH-1:PHT_ENT_SEL+2]};

  assign run      = (state_q == RUN);
  assign o_busy   = ~run;
  assign pred_idx = hash(i_pc[2 +: PHT_ENT_SEL], ghr_q);
  assign trn_idx  = hash(i_resolve_pc[2 +: PHT_ENT_SEL],
                         i_resolve_ghr);
  assign pred_ctr = pht[pred_idx];
  assign trn_ctr  = pht[trn_idx];

  assign o_pred_jmpcond = run & pred_ctr[CTR_WIDTH-1];
  assign o_pred_ghr     = ghr_q;

  always_comb begin
    trn_new = trn_ctr;
    if (i_resolve_jmpcond) begin
      if (trn_ctr != CMAX) trn_new = trn_ctr + 1'b1;
    end else begin
      if (trn_ctr != '0) trn_new = trn_ctr - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!run && sweep_q == idx_t'('1)) state_d = RUN;
  end

  // Repair wins over a same-cycle shift: the front end is redirected.
  assign repair = run & i_resolve_valid & i_resolve_mispred;
  assign shift  = run & i_pred_req & ~repair;

  always_comb begin
    ghr_d = ghr_q;
    unique case (1'b1)
      repair: ghr_d = {i_resolve_ghr[GHR_WIDTH-2:0],
                       i_resolve_jmpcond};
      shift:  ghr_d = {ghr_q[GHR_WIDTH-2:0],
                       o_pred_jmpcond};
      default: ghr_d = ghr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      ghr_q   <= ghr_d;
      if (!run) sweep_q <= sweep_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      pht[sweep_q] <= CINIT;
    end else if (i_resolve_valid) begin
      pht[trn_idx] <= trn_new;
    end
  end

endmodule

// File: tb/tb_gshare_predictor_v2.sv
// Bench for gshare_predictor_v2: directed steps plus random traffic
// against an array-based reference model.
module tb_gshare_predictor_v2;

  logic        clk = 0;
  logic        rst_n;
  logic [31:0] pc, rpc;
  logic        req, rv, rj, rmis;
  logic [9:0]  rghr;
  logic        pred, busy;
  logic [9:0]  pghr;

  logic [31:0] b_pc, b_rpc;
  logic        b_req, b_rv, b_rj, b_rmis;
  logic [9:0]  b_rghr;
  logic        b_pred, b_busy;
  logic [9:0]  b_pghr;

  int errors = 0;
  int checks = 0;

  int pht_m [1024];
  int ghr_m;
  int busy_cnt;

  always #5 clk = ~clk;

  gshare_predictor_v2 dut (
    .clk(clk), .rst_n(rst_n),
    .i_pc(pc), .i_pred_req(req),
    .o_pred_jmpcond(pred), .o_pred_ghr(pghr),
    .o_busy(busy),
    .i_resolve_valid(rv), .i_resolve_pc(rpc),
    .i_resolve_ghr(rghr), .i_resolve_jmpcond(rj),
    .i_resolve_mispred(rmis)
  );

  gshare_predictor_v2 #(.HASH_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_pc(b_pc), .i_pred_req(b_req),
    .o_pred_jmpcond(b_pred), .o_pred_ghr(b_pghr),
    .o_busy(b_busy),
    .i_resolve_valid(b_rv), .i_resolve_pc(b_rpc),
    .i_resolve_ghr(b_rghr), .i_resolve_jmpcond(b_rj),
    .i_resolve_mispred(b_rmis)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int midx(input logic [31:0] p,
                              input int g);
    return ((p >> 2) % 1024) ^ (g % 1024);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) pht_m[i] = 1;
    ghr_m    = 0;
    busy_cnt = 1024;
  endtask

  task automatic idle_a();
    req = 0; rv = 0; rj = 0; rmis = 0;
  endtask

  // Check outputs, advance the model, cross one clock edge.
  task automatic tick();
    int  t;
    bit  bm;
    bit  ep;
    #1;
    bm = busy_cnt > 0;
    ep = !bm && pht_m[midx(pc, ghr_m)] >= 2;
    chk("pred", pred, ep);
    chk("ghr", pghr, ghr_m);
    chk("busy", busy, bm);
    chk("b_busy", b_busy, bm);
    if (bm) begin
      busy_cnt--;
    end else begin
      if (rv) begin
        t = midx(rpc, rghr);
        if (rj) pht_m[t] = (pht_m[t] < 3) ? pht_m[t] + 1 : 3;
        else    pht_m[t] = (pht_m[t] > 0) ? pht_m[t] - 1 : 0;
      end
      if (rv && rmis)
        ghr_m = ((rghr * 2) + rj) % 1024;
      else if (req)
        ghr_m = ((ghr_m * 2) + ep) % 1024;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    pc = 0; rpc = 0; rghr = 0;
    idle_a();
    b_pc = 0; b_rpc = 0; b_rghr = 0;
    b_req = 0; b_rv = 0; b_rj = 0; b_rmis = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_pred", pred, 0);
    chk("rst_ghr", pghr, 0);
    rst_n = 1;

    // Init sweep with random traffic that must be ignored.
    for (int i = 0; i < 1024; i++) begin
      pc   = $urandom;
      req  = 1'($urandom);
      rv   = 1'($urandom);
      rpc  = $urandom;
      rghr = 10'($urandom);
      rj   = 1'($urandom);
      rmis = 1'($urandom);
      tick();
    end
    idle_a();
    #1;
    chk("busy_done", busy, 0);
    chk("ghr_after_init", pghr, 0);

    for (int i = 0; i < 1024; i++) begin
      pc = i * 4;
      tick();
    end

    // Saturation at idx 0x040.
    rv = 1; rpc = 32'h100; rghr = 0; rj = 1;
    repeat (3) tick();
    rv = 0; pc = 32'h100;
    #1 chk("sat_taken", pred, 1);
    rv = 1; rj = 0;
    repeat (4) tick();
    rv = 0;
    #1 chk("sat_nt", pred, 0);
    rv = 1; rj = 1;
    tick();
    rv = 0;
    #1 chk("sat_floor", pred, 0);
    tick();

    // GHR shift: predictions 1,0,1.
    rv = 1; rj = 1; rpc = 32'h400; rghr = 0;
    tick();
    rpc = 32'hC00; rghr = 10'h002;
    tick();
    rv = 0;
    req = 1; pc = 32'h400;
    #1 chk("sh0_ghr", pghr, 0);
    chk("sh0_pred", pred, 1);
    tick();
    pc = 32'h800;
    #1 chk("sh1_ghr", pghr, 1);
    chk("sh1_pred", pred, 0);
    tick();
    pc = 32'hC00;
    #1 chk("sh2_ghr", pghr, 2);
    chk("sh2_pred", pred, 1);
    tick();
    req = 0;
    #1 chk("sh_final", pghr, 10'h005);

    // Mispredict repair overrides same-cycle shift.
    req = 1; pc = 32'h400;
    rv = 1; rmis = 1; rghr = 10'h3A5; rj = 1; rpc = 0;
    tick();
    idle_a();
    #1 chk("repair", pghr, 10'h34B);

    // Same-index predict and train.
    pc = 32'h1000;
    rv = 1; rpc = 32'h1000; rghr = 10'h34B; rj = 1;
    #1 chk("coll_old", pred, 0);
    tick();
    rv = 0;
    #1 chk("coll_new", pred, 1);
    tick();

    // Random traffic over a small PC range.
    for (int i = 0; i < 400; i++) begin
      pc   = 32'($urandom_range(0, 63)) * 4;
      req  = 1'($urandom);
      rv   = 1'($urandom);
      rpc  = 32'($urandom_range(0, 63)) * 4;
      rghr = 10'($urandom);
      rj   = 1'($urandom);
      rmis = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle_a();
    tick();

    // Bimodal instance ignores the GHR.
    b_pc = 32'h100;
    #1 chk("b_pred_init", b_pred, 0);
    tick();
    b_rv = 1; b_rpc = 32'h100; b_rghr = 10'h155; b_rj = 1;
    tick();
    b_rv = 0;
    #1 chk("b_pred_g0", b_pred, 1);
    chk("b_ghr0", b_pghr, 0);
    tick();
    b_rv = 1; b_rmis = 1; b_rghr = 10'h3FF;
    tick();
    b_rv = 0; b_rmis = 0;
    #1 chk("b_ghr_ff", b_pghr, 10'h3FF);
    chk("b_pred_gff", b_pred, 1);
    tick();

    // Async reset mid-run.
    #2 rst_n = 0;
    #1 chk("mid_busy", busy, 1);
    chk("mid_ghr", pghr, 0);
    chk("mid_pred", pred, 0);
    chk("mid_b_busy", b_busy, 1);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 1024; i++) tick();
    for (int i = 0; i < 1024; i++) begin
      pc = i * 4;
      tick();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
